chunked_adder_seq: RTL and testbench
====================================

# chunked_adder_seq

Parametrised multi-cycle adder/subtractor, the sequential successor to the 64-bit behavioral full adder. It computes A+B or A−B over WIDTH/CHUNK clock cycles, one CHUNK-bit slice per cycle, with a registered carry between slices. A start/busy/done handshake lets wide arithmetic share one narrow adder slice, trading latency for area in datapaths that do not need single-cycle sums.

## Interface
- WIDTH, 64, operand width in bits; must be a multiple of CHUNK.
- CHUNK, 16, bits added per cycle; N = WIDTH/CHUNK slices (N ≥ 1).
- clk  input  1  rising-edge clock, the only clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- sub  input  1  0 = add, 1 = subtract; latched with operands.
- A  input  WIDTH  unsigned/two's-complement operand.
- B  input  WIDTH  operand.
- busy  output  1  high while an operation is in flight.
- done  output  1  one-cycle pulse when SUM/ovf are updated.
- SUM  output  WIDTH+1  result; bit WIDTH is carry-out (add) or not-borrow (sub).
- ovf  output  1  signed overflow of the WIDTH-bit result.

## Operation
- States: IDLE, RUN. Reset forces IDLE, slice index 0, carry 0, busy=0, done=0, SUM=0, ovf=0.
- IDLE, start=1: latch A, B' = sub ? ~B : B, carry-in = sub, index=0; go RUN. start=0: stay.
- RUN, each cycle: slice i of A + slice i of B' + carry → slice i of internal accumulator; carry register ← slice carry-out; index++.
- On slice N−1: SUM ← {final carry, accumulator}; ovf ← (A[W−1] == B'[W−1]) && (result[W−1] != A[W−1]); done=1 for that one cycle; go IDLE.
- Add: SUM = A + B exactly (WIDTH+1 bits, no truncation).
- Sub: SUM[WIDTH−1:0] = (A − B) mod 2^WIDTH; SUM[WIDTH] = 1 iff A ≥ B unsigned.
- SUM and ovf change only on the done edge; during RUN they hold the previous result.
- start while busy ignored (no queueing); A, B, sub changes during RUN have no effect.
- start high in the cycle done is high is accepted (state is IDLE then).
- reset mid-RUN aborts: no done pulse, outputs to reset values next cycle.

## Timing
- Edge e0: start=1 sampled in IDLE → busy=1 from after e0.
- Edges e1..eN: slices 0..N−1 processed.
- After eN: done=1, busy=0, SUM/ovf valid; after eN+1: done=0, SUM/ovf held.
- Latency: N edges from accept to result. Earliest next accept at eN+1; throughput one op per N+1 cycles.
- N=1 (CHUNK=WIDTH): result one edge after accept, same rules.
- busy and done never high simultaneously; done is never high two consecutive cycles.
- All outputs registered; no combinational path input→output.

## Test plan
- Reset: hold reset 2 cycles with start=1 → busy=0, done=0, SUM=0, ovf=0; no op started.
- Add carry across slices (64/16): A=0xFFFF_FFFF_FFFF_FFFF, B=1, sub=0 → done exactly 4 edges after accept, SUM=0x1_0000_0000_0000_0000, ovf=0; busy high 4 cycles.
- Sub with borrow and signed overflow: A=0x8000_0000_0000_0000, B=1, sub=1 → SUM[63:0]=0x7FFF_FFFF_FFFF_FFFF, SUM[64]=1, ovf=1; then A=3, B=5, sub=1 → SUM[63:0]=0xFFFF_FFFF_FFFF_FFFE, SUM[64]=0, ovf=0.
- Handshake: pulse start while busy with A=7,B=7 → ignored, first result unchanged, single done; start held during done cycle with A=32,B=32 → accepted, SUM=64 four edges later; SUM holds old value throughout RUN.
- Reset mid-operation: accept A=10,B=20, assert reset after 2 edges → no done pulse, SUM=0; next start A=10,B=20 → SUM=30.
- Sweep: A,B each 0..32 all combinations, add and sub, at (WIDTH,CHUNK) = (64,16), (64,64), (32,8) → every SUM/ovf matches reference model, latency = WIDTH/CHUNK.

Source files
------------

// File: rtl/chunked_adder_seq.sv
// Multi-cycle adder/subtractor: adds one CHUNK-bit slice per clock with a
// registered carry between slices, behind a start/busy/done handshake.
module chunked_adder_seq #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned CHUNK = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic [WIDTH:0]   SUM,
   output logic             ovf
);

   localparam int unsigned N  = WIDTH / CHUNK;
   localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
   localparam logic [IW-1:0] LAST = IW'(N - 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state_q;
   logic [WIDTH-1:0] a_q, b_q, acc_q;
   logic             carry_q;
   logic [IW-1:0]    idx_q;
   logic             busy_q, done_q, ovf_q;
   logic [WIDTH:0]   sum_q;

   int unsigned      off;
   logic [CHUNK:0]   slice_d;
   logic [WIDTH-1:0] acc_d;
   logic             ovf_d;

   // Shared slice adder; b_q already holds ~B for subtraction, carry_q seeds the +1.
   always_comb begin
      off     = CHUNK * 32'(idx_q);
      slice_d = {1'b0, a_q[off +: CHUNK]} + {1'b0, b_q[off +: CHUNK]}
              + {{CHUNK{1'b0}}, carry_q};
      acc_d   = acc_q;
      acc_d[off +: CHUNK] = slice_d[CHUNK-1:0];
      ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (acc_d[WIDTH-1] != a_q[WIDTH-1]);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         carry_q <= 1'b0;
         idx_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         sum_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  a_q     <= A;
                  b_q     <= sub ? ~B : B;
                  carry_q <= sub;
                  idx_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= RUN;
               end
            end
            RUN: begin
               acc_q   <= acc_d;
               carry_q <= slice_d[CHUNK];
               if (idx_q == LAST) begin
                  sum_q   <= {slice_d[CHUNK], acc_d};
                  ovf_q   <= ovf_d;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  idx_q   <= '0;
                  state_q <= IDLE;
               end else begin
                  idx_q <= idx_q + IW'(1);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign SUM  = sum_q;
   assign ovf  = ovf_q;

endmodule

// File: tb/tb_chunked_adder_seq.sv
// Directed and sweep bench for chunked_adder_seq at (64,16), (64,64), (32,8).
module tb_chunked_adder_seq;

   logic        clk = 1'b0;
   logic        reset, start16, startx, sub;
   logic [63:0] A, B;

   logic        busy16, done16, ovf16;
   logic [64:0] sum16;
   logic        busy64, done64, ovf64;
   logic [64:0] sum64;
   logic        busy8, done8, ovf8;
   logic [32:0] sum8;

   int n_cmp = 0;
   int n_err = 0;
   int lat16, lat64, lat8, nd16, nd64, nd8, nb16, ndone;

   always #5 clk = ~clk;

   chunked_adder_seq #(.WIDTH(64), .CHUNK(16)) u_d16 (
      .clk(clk), .reset(reset), .start(start16), .sub(sub), .A(A), .B(B),
      .busy(busy16), .done(done16), .SUM(sum16), .ovf(ovf16));

   chunked_adder_seq #(.WIDTH(64), .CHUNK(64)) u_d64 (
      .clk(clk), .reset(reset), .start(startx), .sub(sub), .A(A), .B(B),
      .busy(busy64), .done(done64), .SUM(sum64), .ovf(ovf64));

   chunked_adder_seq #(.WIDTH(32), .CHUNK(8)) u_d8 (
      .clk(clk), .reset(reset), .start(startx), .sub(sub), .A(A[31:0]), .B(B[31:0]),
      .busy(busy8), .done(done8), .SUM(sum8), .ovf(ovf8));

   task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Returns {ovf, SUM} for a w-bit operation.
   function automatic logic [65:0] model(input logic [63:0] a_in, input logic [63:0] b_in,
                                         input logic s, input int w);
      logic [63:0] mask, a, b, low;
      logic [64:0] r;
      logic        top, o;
      mask = (w == 64) ? '1 : ((64'h1 << w) - 64'h1);
      a = a_in & mask;
      b = b_in & mask;
      if (!s) begin
         r   = {1'b0, a} + {1'b0, b};
         low = r[63:0] & mask;
         top = r[w];
         o   = (a[w-1] == b[w-1]) && (low[w-1] != a[w-1]);
      end else begin
         low = (a - b) & mask;
         top = (a >= b);
         o   = (a[w-1] != b[w-1]) && (low[w-1] != a[w-1]);
      end
      r    = {1'b0, low};
      r[w] = top;
      return {o, r};
   endfunction

   task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic s);
      logic [65:0] e;
      A = a; B = b; sub = s; start16 = 1'b1; startx = 1'b1;
      tick();
      start16 = 1'b0; startx = 1'b0;
      lat16 = 0; lat64 = 0; lat8 = 0; nd16 = 0; nd64 = 0; nd8 = 0;
      nb16 = busy16 ? 1 : 0;
      for (int c = 1; c <= 6; c++) begin
         tick();
         if (busy16) nb16++;
         if (done16) begin nd16++; if (lat16 == 0) lat16 = c; end
         if (done64) begin nd64++; if (lat64 == 0) lat64 = c; end
         if (done8)  begin nd8++;  if (lat8 == 0)  lat8 = c;  end
      end
      e = model(a, b, s, 64);
      check("sum16", sum16, e[64:0]);
      check("ovf16", {64'd0, ovf16}, {64'd0, e[65]});
      check("lat16", 65'(lat16), 65'd4);
      check("ndone16", 65'(nd16), 65'd1);
      check("sum64", sum64, e[64:0]);
      check("ovf64", {64'd0, ovf64}, {64'd0, e[65]});
      check("lat64", 65'(lat64), 65'd1);
      check("ndone64", 65'(nd64), 65'd1);
      e = model(a, b, s, 32);
      check("sum8", {32'd0, sum8}, {32'd0, e[32:0]});
      check("ovf8", {64'd0, ovf8}, {64'd0, e[65]});
      check("lat8", 65'(lat8), 65'd4);
      check("ndone8", 65'(nd8), 65'd1);
   endtask

   initial begin
      // Reset held with start asserted.
      reset = 1'b1; start16 = 1'b1; startx = 1'b1; sub = 1'b0;
      A = 64'd5; B = 64'd6;
      tick();
      tick();
      check("rst_busy", {64'd0, busy16}, 65'd0);
      check("rst_done", {64'd0, done16}, 65'd0);
      check("rst_sum", sum16, 65'd0);
      check("rst_ovf", {64'd0, ovf16}, 65'd0);
      start16 = 1'b0; startx = 1'b0; reset = 1'b0;
      tick();
      check("rst_noop_busy", {64'd0, busy16}, 65'd0);

      // Carry ripple through every slice.
      run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
      check("carry_sum", sum16, 65'h1_0000_0000_0000_0000);
      check("carry_ovf", {64'd0, ovf16}, 65'd0);
      check("carry_busy_cycles", 65'(nb16), 65'd4);

      run_op(64'h8000_0000_0000_0000, 64'd1, 1'b1);
      check("subovf_sum", sum16, 65'h1_7FFF_FFFF_FFFF_FFFF);
      check("subovf_ovf", {64'd0, ovf16}, 65'd1);

      run_op(64'd3, 64'd5, 1'b1);
      check("borrow_sum", sum16, 65'h0_FFFF_FFFF_FFFF_FFFE);
      check("borrow_ovf", {64'd0, ovf16}, 65'd0);

      // Handshake: start during RUN ignored, start during done accepted.
      A = 64'd100; B = 64'd23; sub = 1'b0; start16 = 1'b1;
      tick();
      check("hs_e0_busy", {64'd0, busy16}, 65'd1);
      check("hs_e0_sum", sum16, 65'h0_FFFF_FFFF_FFFF_FFFE);
      A = 64'd7; B = 64'd7; sub = 1'b1;
      ndone = 0;
      tick();
      if (done16) ndone++;
      check("hs_e1_sum", sum16, 65'h0_FFFF_FFFF_FFFF_FFFE);
      tick();
      if (done16) ndone++;
      start16 = 1'b0;
      tick();
      if (done16) ndone++;
      check("hs_e3_busy", {64'd0, busy16}, 65'd1);
      check("hs_e3_sum", sum16, 65'h0_FFFF_FFFF_FFFF_FFFE);
      tick();
      check("hs_e4_done", {64'd0, done16}, 65'd1);
      check("hs_e4_busy", {64'd0, busy16}, 65'd0);
      check("hs_e4_sum", sum16, 65'd123);
      check("hs_no_early_done", 65'(ndone), 65'd0);
      A = 64'd32; B = 64'd32; sub = 1'b0; start16 = 1'b1;
      tick();
      start16 = 1'b0;
      check("hs_e5_done", {64'd0, done16}, 65'd0);
      check("hs_e5_busy", {64'd0, busy16}, 65'd1);
      check("hs_e5_sum", sum16, 65'd123);
      ndone = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (done16) ndone++;
         check("hs_run_sum", sum16, 65'd123);
      end
      check("hs_run_no_done", 65'(ndone), 65'd0);
      tick();
      check("hs_e9_done", {64'd0, done16}, 65'd1);
      check("hs_e9_sum", sum16, 65'd64);
      tick();
      check("hs_e10_done", {64'd0, done16}, 65'd0);
      check("hs_e10_sum", sum16, 65'd64);

      // Reset aborts an operation in flight.
      A = 64'd10; B = 64'd20; sub = 1'b0; start16 = 1'b1;
      tick();
      start16 = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("abort_busy", {64'd0, busy16}, 65'd0);
      check("abort_done", {64'd0, done16}, 65'd0);
      check("abort_sum", sum16, 65'd0);
      ndone = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (done16 || busy16) ndone++;
      end
      check("abort_quiet", 65'(ndone), 65'd0);
      run_op(64'd10, 64'd20, 1'b0);
      check("abort_retry_sum", sum16, 65'd30);

      // Small-operand sweep on all three configurations.
      for (int s = 0; s < 2; s++)
         for (int a = 0; a <= 32; a++)
            for (int b = 0; b <= 32; b++)
               run_op(64'(a), 64'(b), s[0]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
